// File: rtl/e_mdu_pkg.sv
// Shared MDU operation encodings, latency constants and a latency lookup helper.
// The madd/maddu/msub/msubu latencies exist only when MDU_MADD_EN is defined.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_none  = 4'd0,
    MDU_mult  = 4'd1,
    MDU_multu = 4'd2,
    MDU_div   = 4'd3,
    MDU_divu  = 4'd4,
    MDU_mthi  = 4'd5,
    MDU_mtlo  = 4'd6,
    MDU_mfhi  = 4'd7,
    MDU_mflo  = 4'd8,
    MDU_madd  = 4'd9,
    MDU_maddu = 4'd10,
    MDU_msub  = 4'd11,
    MDU_msubu = 4'd12
  } mdu_op_e;

  localparam int unsigned MDU_MULT_CYC = 5;
  localparam int unsigned MDU_DIV_CYC  = 10;

  // Zero means "not a multi-cycle op": Start with such an op does nothing.
  function automatic logic [3:0] mdu_cycles(input mdu_op_e op);
    case (op)
      MDU_mult, MDU_multu: return 4'(MDU_MULT_CYC);
      MDU_div, MDU_divu:   return 4'(MDU_DIV_CYC);
`ifdef MDU_MADD_EN
      MDU_madd, MDU_maddu,
      MDU_msub, MDU_msubu: return 4'(MDU_MULT_CYC);
`endif
      default:             return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage MDU bus: forwarded operands, op/start request, Busy and HI/LO/read result.
interface e_mdu_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut;

  modport master (
    output A, B, MDUOp, Start,
    input  Busy, HI, LO, MDUOut
  );

  modport slave (
    input  A, B, MDUOp, Start,
    output Busy, HI, LO, MDUOut
  );
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; results commit on the final busy edge.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu (accumulate into {HI,LO}).
module e_mdu
  import e_mdu_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  e_mdu_if.slave mdu
);

  mdu_op_e     op_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [3:0]  cnt_reg;
  logic        busy_reg;

  mdu_op_e     op_in;
  logic [3:0]  start_cyc;
  logic [63:0] res_next;
  logic        wr_next;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a, abs_b, sdiv, uq, ur, sq, sr;
  logic [31:0] udiv, dq, dr;

  assign op_in     = mdu_op_e'(mdu.MDUOp);
  assign start_cyc = mdu_cycles(op_in);

  // Signed divide runs on magnitudes so that 0x80000000 / -1 wraps cleanly to 0x80000000.
  always_comb begin
    prod_s = {{32{a_reg[31]}}, a_reg} * {{32{b_reg[31]}}, b_reg};
    prod_u = {32'd0, a_reg} * {32'd0, b_reg};
    abs_a  = a_reg[31] ? -a_reg : a_reg;
    abs_b  = b_reg[31] ? -b_reg : b_reg;
    sdiv   = (abs_b == 32'd0) ? 32'd1 : abs_b;
    uq     = abs_a / sdiv;
    ur     = abs_a % sdiv;
    sq     = (a_reg[31] ^ b_reg[31]) ? -uq : uq;
    sr     = a_reg[31] ? -ur : ur;
    udiv   = (b_reg == 32'd0) ? 32'd1 : b_reg;
    dq     = a_reg / udiv;
    dr     = a_reg % udiv;
  end

  always_comb begin
    res_next = {hi_reg, lo_reg};
    wr_next  = 1'b1;
    case (op_reg)
      MDU_mult:  res_next = prod_s;
      MDU_multu: res_next = prod_u;
      MDU_div: begin
        if (b_reg == 32'd0) wr_next = 1'b0;
        else                res_next = {sr, sq};
      end
      MDU_divu: begin
        if (b_reg == 32'd0) wr_next = 1'b0;
        else                res_next = {dr, dq};
      end
`ifdef MDU_MADD_EN
      MDU_madd:  res_next = {hi_reg, lo_reg} + prod_s;
      MDU_maddu: res_next = {hi_reg, lo_reg} + prod_u;
      MDU_msub:  res_next = {hi_reg, lo_reg} - prod_s;
      MDU_msubu: res_next = {hi_reg, lo_reg} - prod_u;
`endif
      default:   wr_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg   <= MDU_none;
      a_reg    <= 32'd0;
      b_reg    <= 32'd0;
      hi_reg   <= 32'd0;
      lo_reg   <= 32'd0;
      cnt_reg  <= 4'd0;
      busy_reg <= 1'b0;
    end else if (busy_reg) begin
      // While busy, Start/mthi/mtlo are dropped; only the countdown advances.
      if (cnt_reg == 4'd1) begin
        cnt_reg  <= 4'd0;
        busy_reg <= 1'b0;
        if (wr_next) {hi_reg, lo_reg} <= res_next;
      end else begin
        cnt_reg <= cnt_reg - 4'd1;
      end
    end else if (mdu.Start && (start_cyc != 4'd0)) begin
      op_reg   <= op_in;
      a_reg    <= mdu.A;
      b_reg    <= mdu.B;
      cnt_reg  <= start_cyc;
      busy_reg <= 1'b1;
    end else if (op_in == MDU_mthi) begin
      hi_reg <= mdu.A;
    end else if (op_in == MDU_mtlo) begin
      lo_reg <= mdu.A;
    end
  end

  always_comb begin
    mdu.MDUOut = 32'd0;
    if (op_in == MDU_mfhi)      mdu.MDUOut = hi_reg;
    else if (op_in == MDU_mflo) mdu.MDUOut = lo_reg;
  end

  assign mdu.Busy = busy_reg;
  assign mdu.HI   = hi_reg;
  assign mdu.LO   = lo_reg;

endmodule

// File: tb/tb_e_mdu.sv
// Directed + randomized bench for e_mdu; expected {HI,LO} values go through a scoreboard queue.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [63:0] exp_q[$];
  logic [63:0] cur;

  e_mdu_if mdu ();

  e_mdu dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mdu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  // Reference behaviour written directly from the instruction definitions.
  function automatic logic [63:0] model(input mdu_op_e op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     ps, pu, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ps = sa * sb;
    pu = ua * ub;
    case (op)
      MDU_mult:  return ps;
      MDU_multu: return pu;
      MDU_div: begin
        if (b == 32'd0) return acc;
        q = sa / sb; r = sa % sb;
        qv = q; rv = r;
        return {rv[31:0], qv[31:0]};
      end
      MDU_divu: begin
        if (b == 32'd0) return acc;
        qv = ua / ub; rv = ua % ub;
        return {rv[31:0], qv[31:0]};
      end
      MDU_madd:  return acc + ps;
      MDU_maddu: return acc + pu;
      MDU_msub:  return acc - ps;
      MDU_msubu: return acc - pu;
      default:   return acc;
    endcase
  endfunction

  // inj: 0 none, 1 Start-div during busy, 2 mthi during busy.
  task automatic run_op(input string tag, input mdu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [63:0] expv,
                        input int inj);
    int n;
    logic [63:0] got;
    exp_q.push_back(expv);
    mdu.A = a; mdu.B = b; mdu.MDUOp = op; mdu.Start = 1'b1;
    @(posedge clk); #1;
    mdu.Start = 1'b0; mdu.MDUOp = MDU_mfhi;
    #1;
    check({tag, "_busy_rise"}, {63'd0, mdu.Busy}, 64'd1);
    check({tag, "_mfhi_busy"}, {32'd0, mdu.MDUOut}, {32'd0, cur[63:32]});
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 2 && inj == 1) begin
        mdu.Start = 1'b1; mdu.MDUOp = MDU_div; mdu.A = 32'd100; mdu.B = 32'd7;
      end
      if (n == 2 && inj == 2) begin
        mdu.MDUOp = MDU_mthi; mdu.A = 32'hDEAD_BEEF;
      end
      if (n == 3) begin
        mdu.Start = 1'b0; mdu.MDUOp = MDU_mfhi;
      end
      if (!mdu.Busy) break;
    end
    #1;
    check({tag, "_latency"}, 64'(n), 64'(lat));
    got = exp_q.pop_front();
    check({tag, "_hilo"}, {mdu.HI, mdu.LO}, got);
    check({tag, "_mfhi_after"}, {32'd0, mdu.MDUOut}, {32'd0, got[63:32]});
    mdu.MDUOp = MDU_mflo; #1;
    check({tag, "_mflo_after"}, {32'd0, mdu.MDUOut}, {32'd0, got[31:0]});
    cur = got;
    mdu.MDUOp = MDU_none;
    @(posedge clk); #1;
    check({tag, "_idle"}, {63'd0, mdu.Busy}, 64'd0);
    $display("txn %s op=%0d a=%h b=%h hi=%h lo=%h cyc=%0d", tag, op, a, b, mdu.HI, mdu.LO, n);
  endtask

  task automatic move_to(input mdu_op_e op, input logic [31:0] a);
    mdu.MDUOp = op; mdu.A = a;
    @(posedge clk); #1;
    if (op == MDU_mthi) cur[63:32] = a;
    else                cur[31:0]  = a;
    mdu.MDUOp = MDU_none;
  endtask

  initial begin
    mdu_op_e     rop;
    logic [31:0] ra, rb;
    total = 0; bad = 0;
    reset = 1'b1;
    mdu.A = 32'd0; mdu.B = 32'd0; mdu.MDUOp = MDU_none; mdu.Start = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    cur = 64'd0;
    mdu.MDUOp = MDU_mfhi; #1;
    check("reset_busy", {63'd0, mdu.Busy}, 64'd0);
    check("reset_hilo", {mdu.HI, mdu.LO}, 64'd0);
    check("reset_mfhi", {32'd0, mdu.MDUOut}, 64'd0);
    mdu.MDUOp = MDU_none; #1;
    check("none_out", {32'd0, mdu.MDUOut}, 64'd0);

    run_op("mult",  MDU_mult,  32'hFFFF_FFFE, 32'h0000_0003, 5, 64'hFFFF_FFFF_FFFF_FFFA, 0);
    run_op("multu", MDU_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 64'hFFFF_FFFE_0000_0001, 0);
    run_op("div",   MDU_div,   32'hFFFF_FFF9, 32'h0000_0002, 10, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("divu0", MDU_divu,  32'h0000_0007, 32'h0000_0000, 10, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("divovf", MDU_div,  32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000, 0);
    run_op("div0",  MDU_div,   32'h1234_0000, 32'h0000_0000, 10, 64'h0000_0000_8000_0000, 0);
    run_op("ignstart", MDU_mult, 32'h0000_0003, 32'hFFFF_FFFC, 5, 64'hFFFF_FFFF_FFFF_FFF4, 1);
    run_op("ignmthi",  MDU_multu, 32'h0001_0000, 32'h0001_0000, 5, 64'h0000_0001_0000_0000, 2);

    move_to(MDU_mthi, 32'h1234_5678);
    mdu.MDUOp = MDU_mfhi; #1;
    check("mthi_mfhi", {32'd0, mdu.MDUOut}, 64'h0000_0000_1234_5678);
    move_to(MDU_mtlo, 32'h9ABC_DEF0);
    mdu.MDUOp = MDU_mflo; #1;
    check("mtlo_mflo", {32'd0, mdu.MDUOut}, 64'h0000_0000_9ABC_DEF0);
    check("mt_hilo", {mdu.HI, mdu.LO}, 64'h1234_5678_9ABC_DEF0);
    mdu.MDUOp = MDU_none;

    // Reset in the 4th busy cycle of a divide aborts it with no later write.
    mdu.A = 32'd1000; mdu.B = 32'd3; mdu.MDUOp = MDU_div; mdu.Start = 1'b1;
    @(posedge clk); #1;
    mdu.Start = 1'b0; mdu.MDUOp = MDU_none;
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    cur = 64'd0;
    check("rst_abort_hilo", {mdu.HI, mdu.LO}, 64'd0);
    check("rst_abort_busy", {63'd0, mdu.Busy}, 64'd0);
    repeat (12) @(posedge clk);
    #1;
    check("rst_no_write", {mdu.HI, mdu.LO}, 64'd0);
    $display("txn rst_abort hi=%h lo=%h busy=%b", mdu.HI, mdu.LO, mdu.Busy);

    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       rop = MDU_mult;
        1:       rop = MDU_multu;
        2:       rop = MDU_div;
        default: rop = MDU_divu;
      endcase
      ra = $urandom();
      rb = (i == 5) ? 32'd0 : $urandom();
      if (i == 6) rb = 32'hFFFF_FFF0 | (rb & 32'h0000_000F) | 32'd1;
      run_op("rand", rop, ra, rb, (rop == MDU_div || rop == MDU_divu) ? 10 : 5,
             model(rop, ra, rb, cur), 0);
    end

`ifdef MDU_MADD_EN
    move_to(MDU_mthi, 32'd0);
    move_to(MDU_mtlo, 32'd1);
    run_op("madd", MDU_madd, 32'd2, 32'd3, 5, 64'h0000_0000_0000_0007, 0);
    run_op("msub", MDU_msub, 32'd5, 32'hFFFF_FFFF, 5, model(MDU_msub, 32'd5, 32'hFFFF_FFFF, cur), 0);
    run_op("maddu", MDU_maddu, 32'hFFFF_FFFF, 32'd2, 5, model(MDU_maddu, 32'hFFFF_FFFF, 32'd2, cur), 0);
    run_op("msubu", MDU_msubu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
           model(MDU_msubu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cur), 0);
`else
    // madd-class encodings act as none when the feature is compiled out.
    mdu.A = 32'd2; mdu.B = 32'd3; mdu.MDUOp = MDU_madd; mdu.Start = 1'b1;
    @(posedge clk); #1;
    mdu.Start = 1'b0; mdu.MDUOp = MDU_none;
    check("madd_off_busy", {63'd0, mdu.Busy}, 64'd0);
    check("madd_off_hilo", {mdu.HI, mdu.LO}, cur);
    $display("txn madd_off hi=%h lo=%h busy=%b", mdu.HI, mdu.LO, mdu.Busy);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
